// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: round-robin share of one fixed-latency memory port       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_in
);

    localparam int              c_cnt_w    = $clog2(MEM_LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MEM_LATENCY);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_ptr;
    logic                  r_owner;
    logic                  r_we;
    logic                  r_gnt0, r_gnt1, r_done0, r_done1, r_busy, r_mem_we;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data_out;

    logic w_any;
    logic w_pick;
    logic w_take;
    logic w_last;
    logic w_gnt0_nxt, w_gnt1_nxt, w_done0_nxt, w_done1_nxt, w_busy_nxt, w_we_nxt;

    // w_pick = 1 selects requester 1; the pointer only matters on a tie
    assign w_any  = req0 | req1;
    assign w_pick = (req0 && req1) ? r_ptr : req1;
    assign w_take = (r_state == c_st_idle) && w_any;
    assign w_last = (r_state == c_st_access) && (r_cnt == c_cnt_one);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_any) w_state_nxt = c_st_access;
            c_st_access: if (w_last) w_state_nxt = c_st_resp;
            c_st_resp:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_gnt0_nxt  = w_take && !w_pick;
        w_gnt1_nxt  = w_take && w_pick;
        w_we_nxt    = w_take && (w_pick ? we1 : we0);
        w_done0_nxt = w_last && !r_owner;
        w_done1_nxt = w_last && r_owner;
        w_busy_nxt  = (w_state_nxt != c_st_idle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt          <= '0;
            r_ptr          <= 1'b0;
            r_owner        <= 1'b0;
            r_we           <= 1'b0;
            r_gnt0         <= 1'b0;
            r_gnt1         <= 1'b0;
            r_done0        <= 1'b0;
            r_done1        <= 1'b0;
            r_busy         <= 1'b0;
            r_mem_we       <= 1'b0;
            r_rdata0       <= '0;
            r_rdata1       <= '0;
            r_mem_address  <= '0;
            r_mem_data_out <= '0;
        end else begin
            r_gnt0   <= w_gnt0_nxt;
            r_gnt1   <= w_gnt1_nxt;
            r_done0  <= w_done0_nxt;
            r_done1  <= w_done1_nxt;
            r_busy   <= w_busy_nxt;
            r_mem_we <= w_we_nxt;
            if (w_take) begin
                r_owner        <= w_pick;
                r_we           <= w_pick ? we1 : we0;
                r_mem_address  <= w_pick ? addr1 : addr0;
                r_mem_data_out <= w_pick ? wdata1 : wdata0;
                r_cnt          <= c_cnt_load;
                r_ptr          <= ~r_ptr;
            end else if (r_state == c_st_access) begin
                r_cnt <= r_cnt - c_cnt_one;
                // Read data is sampled only once the address has been held MEM_LATENCY cycles
                if (w_last && !r_we) begin
                    if (r_owner) r_rdata1 <= mem_data_in;
                    else         r_rdata0 <= mem_data_in;
                end
            end
        end
    end

    assign gnt0         = r_gnt0;
    assign gnt1         = r_gnt1;
    assign done0        = r_done0;
    assign done1        = r_done1;
    assign rdata0       = r_rdata0;
    assign rdata1       = r_rdata1;
    assign busy         = r_busy;
    assign mem_we       = r_mem_we;
    assign mem_address  = r_mem_address;
    assign mem_data_out = r_mem_data_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed bench, latency-1 (a) and latency-3 (b) DUTs  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        mem_init = 1'b1;

    logic        gnt0_a, gnt1_a, done0_a, done1_a, busy_a, mem_we_a;
    logic [31:0] rdata0_a, rdata1_a, mem_address_a, mem_data_out_a, mem_data_in_a;
    logic        gnt0_b, gnt1_b, done0_b, done1_b, busy_b, mem_we_b;
    logic [31:0] rdata0_b, rdata1_b, mem_address_b, mem_data_out_b, mem_data_in_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a),
        .mem_address(mem_address_a), .mem_data_out(mem_data_out_a),
        .mem_we(mem_we_a), .mem_data_in(mem_data_in_a)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b),
        .mem_address(mem_address_b), .mem_data_out(mem_data_out_b),
        .mem_we(mem_we_b), .mem_data_in(mem_data_in_b)
    );

    // Fixed-latency memories: combinational read, write on the edge closing a mem_we cycle
    assign mem_data_in_a = mem_a[mem_address_a[7:0]];
    assign mem_data_in_b = mem_b[mem_address_b[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
            mem_a[8'h10] <= 32'hDEADBEEF;
            mem_b[8'h10] <= 32'hDEADBEEF;
            mem_b[8'h40] <= 32'hCAFEF00D;
        end else begin
            if (mem_we_a) mem_a[mem_address_a[7:0]] <= mem_data_out_a;
            if (mem_we_b) mem_b[mem_address_b[7:0]] <= mem_data_out_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_gnt0", 64'(gnt0_a), 64'd0);
        chk("rst_gnt1", 64'(gnt1_a), 64'd0);
        chk("rst_done0", 64'(done0_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_mem_we", 64'(mem_we_a), 64'd0);
        chk("rst_rdata0", 64'(rdata0_a), 64'd0);
        chk("rst_mem_addr", 64'(mem_address_a), 64'd0);
        mem_init = 1'b0;
        resetn   = 1'b1;
        idle(2);

        // Latency-1 read of 0x10 by requester 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        tick();
        req0 = 1'b0;
        chk("rd_gnt0", 64'(gnt0_a), 64'd1);
        chk("rd_gnt1", 64'(gnt1_a), 64'd0);
        chk("rd_addr", 64'(mem_address_a), 64'h10);
        chk("rd_busy", 64'(busy_a), 64'd1);
        chk("rd_done0_early", 64'(done0_a), 64'd0);
        tick();
        chk("rd_done0", 64'(done0_a), 64'd1);
        chk("rd_done1", 64'(done1_a), 64'd0);
        chk("rd_gnt0_pulse", 64'(gnt0_a), 64'd0);
        chk("rd_rdata0", 64'(rdata0_a), 64'hDEADBEEF);
        tick();
        chk("rd_done0_pulse", 64'(done0_a), 64'd0);
        chk("rd_busy_idle", 64'(busy_a), 64'd0);
        idle(5);

        // Requester 1 writes 0x12345678 to 0x20
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
        tick();
        req1 = 1'b0;
        chk("wr_gnt1", 64'(gnt1_a), 64'd1);
        chk("wr_mem_we", 64'(mem_we_a), 64'd1);
        chk("wr_addr", 64'(mem_address_a), 64'h20);
        chk("wr_dout", 64'(mem_data_out_a), 64'h12345678);
        tick();
        chk("wr_mem_we_pulse", 64'(mem_we_a), 64'd0);
        chk("wr_done1", 64'(done1_a), 64'd1);
        chk("wr_rdata1", 64'(rdata1_a), 64'd0);
        idle(5);

        // Read back 0x20 through requester 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        tick();
        req0 = 1'b0;
        chk("rb_gnt0", 64'(gnt0_a), 64'd1);
        tick();
        chk("rb_done0", 64'(done0_a), 64'd1);
        chk("rb_rdata0", 64'(rdata0_a), 64'h12345678);
        idle(5);

        // Fresh pointer, then both requesters held for four transactions
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_gnt0_%0d", k), 64'(gnt0_a), 64'((k % 2) == 0));
            chk($sformatf("rr_gnt1_%0d", k), 64'(gnt1_a), 64'((k % 2) == 1));
            tick();
            chk($sformatf("rr_done0_%0d", k), 64'(done0_a), 64'((k % 2) == 0));
            chk($sformatf("rr_done1_%0d", k), 64'(done1_a), 64'((k % 2) == 1));
            if ((k % 2) == 0) chk($sformatf("rr_rdata0_%0d", k), 64'(rdata0_a), 64'hDEADBEEF);
            else              chk($sformatf("rr_rdata1_%0d", k), 64'(rdata1_a), 64'h12345678);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            chk($sformatf("rr_busy_idle_%0d", k), 64'(busy_a), 64'd0);
        end
        idle(8);

        // Latency-3 read of 0x40
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        tick();
        req0 = 1'b0;
        chk("l3_gnt0", 64'(gnt0_b), 64'd1);
        chk("l3_addr1", 64'(mem_address_b), 64'h40);
        tick();
        chk("l3_addr2", 64'(mem_address_b), 64'h40);
        chk("l3_done_c2", 64'(done0_b), 64'd0);
        chk("l3_rdata_c2", 64'(rdata0_b), 64'd0);
        tick();
        chk("l3_addr3", 64'(mem_address_b), 64'h40);
        chk("l3_done_c3", 64'(done0_b), 64'd0);
        chk("l3_busy_c3", 64'(busy_b), 64'd1);
        tick();
        chk("l3_done0", 64'(done0_b), 64'd1);
        chk("l3_rdata0", 64'(rdata0_b), 64'hCAFEF00D);
        idle(6);

        // Reset asserted during the second ACCESS cycle of a latency-3 read
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        tick();
        req0 = 1'b0;
        chk("ar_gnt0", 64'(gnt0_b), 64'd1);
        tick();
        resetn = 1'b0;
        #1;
        chk("ar_busy", 64'(busy_b), 64'd0);
        chk("ar_mem_we", 64'(mem_we_b), 64'd0);
        chk("ar_gnt0", 64'(gnt0_b), 64'd0);
        chk("ar_done0", 64'(done0_b), 64'd0);
        chk("ar_addr", 64'(mem_address_b), 64'd0);
        chk("ar_rdata0", 64'(rdata0_b), 64'd0);
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("ar_no_done0_%0d", k), 64'(done0_b), 64'd0);
        end
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h20;
        tick();
        req0 = 1'b0; req1 = 1'b0;
        chk("ar_tie_gnt0", 64'(gnt0_b), 64'd1);
        chk("ar_tie_gnt1", 64'(gnt1_b), 64'd0);
        idle(8);

        // req0 held across done0 on the latency-1 DUT
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        tick();
        chk("bb_gnt0_first", 64'(gnt0_a), 64'd1);
        tick();
        chk("bb_done0", 64'(done0_a), 64'd1);
        chk("bb_busy_resp", 64'(busy_a), 64'd1);
        tick();
        chk("bb_busy_gap", 64'(busy_a), 64'd0);
        chk("bb_gnt0_gap", 64'(gnt0_a), 64'd0);
        tick();
        req0 = 1'b0;
        chk("bb_gnt0_second", 64'(gnt0_a), 64'd1);
        chk("bb_busy_back", 64'(busy_a), 64'd1);
        tick();
        chk("bb_done0_second", 64'(done0_a), 64'd1);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
